// File: rtl/ux607_uartrx_pkg.sv
// ---------------------------------------------------------------------------
// ux607_uartrx_pkg
//  Shared types and helpers for the UART receive engine.
//   - state_t      : receiver FSM state encoding
//   - half/full-bit timer reload helpers, expressed in oversample ticks
//   - majority3    : 2-of-3 vote used by the bit sampler
// ---------------------------------------------------------------------------
package ux607_uartrx_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   // Timer expires when it has counted down through zero, so a reload of N
   // spans N+1 ticks. The half-bit value lands the first sample just past the
   // centre of the start bit; every later sample is one full bit apart.
   function automatic int half_bit_reload(input int osr_log2);
      return 1 << (osr_log2 - 1);
   endfunction

   function automatic int full_bit_reload(input int osr_log2);
      return (1 << osr_log2) - 1;
   endfunction

   function automatic logic majority3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction

endpackage

// File: rtl/ux607_uartrx_tickgen.sv
// ---------------------------------------------------------------------------
// ux607_uartrx_tickgen
//  Oversample prescaler. Counts down while the receiver is busy and raises
//  tick for one cycle when it reaches zero, reloading at the same time.
//  A reload of R gives one tick every R+1 busy cycles (R=0: every cycle).
//
//  Ports
//   clock    in   rising-edge clock
//   reset    in   synchronous, active-high
//   busy     in   receiver is inside a frame
//   restart  in   start edge accepted; realign the prescaler phase
//   reload   in   prescaler reload value
//   tick     out  oversample strobe (combinational from prescaler state)
// ---------------------------------------------------------------------------
module ux607_uartrx_tickgen
   import ux607_uartrx_pkg::*;
#(
   parameter int RLD_W = 12
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             busy,
   input  logic             restart,
   input  logic [RLD_W-1:0] reload,
   output logic             tick
);

   logic [RLD_W-1:0] prescaler;

   assign tick = busy && (prescaler == '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         prescaler <= '0;
      end else if (restart || tick) begin
         prescaler <= reload;
      end else if (busy) begin
         prescaler <= prescaler - 1'b1;
      end
   end

endmodule

// File: rtl/ux607_uartrx_cfg.sv
// ---------------------------------------------------------------------------
// ux607_uartrx_cfg
//  UART receive engine: start-edge debounce, 2-of-3 majority bit sampling at
//  2**OSR_LOG2 oversampling, run-time data length and stop-bit count, and a
//  single-entry valid/ready output slot with overrun and framing flags.
//
//  Optional feature macro: UX607_UARTRX_PARITY_EN
//   defined   : adds io_par_en / io_par_odd / io_parity_err and a PARITY state
//   undefined : data bits go straight to the stop bit(s)
//
//  Ports
//   clock          in   rising-edge clock
//   reset          in   synchronous, active-high
//   io_en          in   receiver enable; low abandons any frame in flight
//   io_in          in   serial line (already synchronised), idle high
//   io_div         in   bit period; prescaler reload = io_div[DIV_W-1:OSR_LOG2]
//   io_nbits       in   data bits per frame, 5..DATA_W
//   io_nstop       in   0: one stop bit, 1: two stop bits
//   io_out_valid   out  received word available
//   io_out_ready   in   consumer accepts the word
//   io_out_bits    out  received word, right-aligned, upper bits zero
//   io_frame_err   out  1-cycle pulse: a stop bit sampled low
//   io_overrun     out  1-cycle pulse: word completed while slot was full
//   io_par_en      in   (parity build) parity bit present
//   io_par_odd     in   (parity build) 1: odd parity, 0: even
//   io_parity_err  out  (parity build) 1-cycle pulse: parity mismatch
// ---------------------------------------------------------------------------
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | line watched, debounce counter tracks low level
// START   | half-bit wait, then confirm start bit (high = glitch)
// DATA    | one sample per bit, LSB first, bitcnt counts down
// PARITY  | parity bit sampled and compared (parity build only)
// STOP    | one or two stop bits checked, word delivered or flagged
// ---------------------------------------------------------------------------
module ux607_uartrx_cfg
   import ux607_uartrx_pkg::*;
#(
   parameter int DATA_W   = 9,
   parameter int DIV_W    = 16,
   parameter int OSR_LOG2 = 4,
   parameter int DEB_W    = 2
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          io_en,
   input  logic                          io_in,
   input  logic [DIV_W-1:0]              io_div,
   input  logic [$clog2(DATA_W+1)-1:0]   io_nbits,
   input  logic                          io_nstop,
   output logic                          io_out_valid,
   input  logic                          io_out_ready,
   output logic [DATA_W-1:0]             io_out_bits,
`ifdef UX607_UARTRX_PARITY_EN
   input  logic                          io_par_en,
   input  logic                          io_par_odd,
   output logic                          io_parity_err,
`endif
   output logic                          io_frame_err,
   output logic                          io_overrun
);

   localparam int NB_W  = $clog2(DATA_W + 1);
   localparam int RLD_W = DIV_W - OSR_LOG2;

   localparam logic [OSR_LOG2-1:0] TMR_HALF = OSR_LOG2'(half_bit_reload(OSR_LOG2));
   localparam logic [OSR_LOG2-1:0] TMR_FULL = OSR_LOG2'(full_bit_reload(OSR_LOG2));
   localparam logic [DEB_W-1:0]    DEB_MAX  = '1;

   state_t              state;
   logic [OSR_LOG2-1:0] timer;
   logic [NB_W-1:0]     bitcnt;
   logic [DEB_W-1:0]    debounce;
   logic [2:0]          samples;
   logic [DATA_W-1:0]   shifter;
   logic [DATA_W-1:0]   shift_nxt;
   logic [DATA_W-1:0]   out_bits;
   logic                out_valid;
   logic                second_stop;
   logic                discard;
   logic                frame_err_q;
   logic                overrun_q;
`ifdef UX607_UARTRX_PARITY_EN
   logic                parity_err_q;
`endif

   logic                tick;
   logic                expire;
   logic                busy;
   logic                restart;
   logic                maj;
   logic [NB_W-1:0]     msb_idx;
   logic                div_frac_unused;

   // Fractional part of the divider has no effect at this oversample ratio.
   assign div_frac_unused = ^io_div[OSR_LOG2-1:0];

   assign busy    = (state != ST_IDLE);
   assign restart = io_en && (state == ST_IDLE) && !io_in && (debounce == DEB_MAX);
   assign expire  = tick && (timer == '0);

   // The vote includes the sample being taken on this tick, so the decision
   // uses the three most recent oversamples around the bit centre.
   assign maj     = majority3({samples[1:0], io_in});
   assign msb_idx = io_nbits - NB_W'(1);

   // New bit enters at the top of the selected frame width and walks down,
   // so the first (LSB) bit ends up in bit 0 once all bits are in.
   always_comb begin
      shift_nxt          = shifter >> 1;
      shift_nxt[msb_idx] = maj;
   end

   ux607_uartrx_tickgen #(
      .RLD_W (RLD_W)
   ) u_tickgen (
      .clock   (clock),
      .reset   (reset),
      .busy    (busy),
      .restart (restart),
      .reload  (io_div[DIV_W-1:OSR_LOG2]),
      .tick    (tick)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= ST_IDLE;
         timer        <= '0;
         bitcnt       <= '0;
         debounce     <= '0;
         samples      <= '0;
         shifter      <= '0;
         second_stop  <= 1'b0;
         discard      <= 1'b0;
         out_valid    <= 1'b0;
         out_bits     <= '0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef UX607_UARTRX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef UX607_UARTRX_PARITY_EN
         parity_err_q <= 1'b0;
`endif

         if (tick) begin
            samples <= {samples[1:0], io_in};
         end

         // Slot empties after a handshake; a delivery below in the same
         // cycle overrides this and keeps valid high (back-to-back).
         if (out_valid && io_out_ready) begin
            out_valid <= 1'b0;
         end

         if (!io_en) begin
            state    <= ST_IDLE;
            debounce <= '0;
         end else begin
            if (busy && tick) begin
               timer <= expire ? TMR_FULL : timer - 1'b1;
            end

            unique case (state)
               ST_IDLE: begin
                  if (!io_in) begin
                     if (debounce == DEB_MAX) begin
                        state       <= ST_START;
                        timer       <= TMR_HALF;
                        debounce    <= '0;
                        shifter     <= '0;
                        second_stop <= 1'b0;
                        discard     <= 1'b0;
                     end else begin
                        debounce <= debounce + 1'b1;
                     end
                  end else if (debounce != '0) begin
                     debounce <= debounce - 1'b1;
                  end
               end

               ST_START: begin
                  if (expire) begin
                     if (!maj) begin
                        state  <= ST_DATA;
                        bitcnt <= msb_idx;
                     end else begin
                        state <= ST_IDLE;
                     end
                  end
               end

               ST_DATA: begin
                  if (expire) begin
                     shifter <= shift_nxt;
                     if (bitcnt == '0) begin
`ifdef UX607_UARTRX_PARITY_EN
                        state <= io_par_en ? ST_PARITY : ST_STOP;
`else
                        state <= ST_STOP;
`endif
                     end else begin
                        bitcnt <= bitcnt - 1'b1;
                     end
                  end
               end

`ifdef UX607_UARTRX_PARITY_EN
               ST_PARITY: begin
                  if (expire) begin
                     // Mismatch still runs the stop check so a framing
                     // error on the same frame is reported as well.
                     if (((^shifter) ^ io_par_odd) != maj) begin
                        parity_err_q <= 1'b1;
                        discard      <= 1'b1;
                     end
                     state <= ST_STOP;
                  end
               end
`endif

               ST_STOP: begin
                  if (expire) begin
                     if (!maj) begin
                        frame_err_q <= 1'b1;
                        state       <= ST_IDLE;
                     end else if (io_nstop && !second_stop) begin
                        second_stop <= 1'b1;
                     end else begin
                        state <= ST_IDLE;
                        if (!discard) begin
                           if (!out_valid || io_out_ready) begin
                              out_bits  <= shifter;
                              out_valid <= 1'b1;
                           end else begin
                              overrun_q <= 1'b1;
                           end
                        end
                     end
                  end
               end

               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign io_out_valid  = out_valid;
   assign io_out_bits   = out_bits;
   assign io_frame_err  = frame_err_q;
   assign io_overrun    = overrun_q;
`ifdef UX607_UARTRX_PARITY_EN
   assign io_parity_err = parity_err_q;
`endif

endmodule
